// File: rtl/aes_dec_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_dec_iter_ctrl                                                          |
// | Iterative AES-128 decryptor: cached key schedule, one round per clock.     |
// | Optional: AES_DEC_RK_OUT_EN exposes the last round key on rk_last.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_dec_iter_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_vld,
  input  logic [127:0] key_in,
  output logic         key_rdy,
  output logic         key_ok,
  input  logic         ct_vld,
  input  logic [127:0] ct_in,
  output logic         ct_rdy,
  output logic         pt_vld,
  output logic [127:0] pt_out,
`ifdef AES_DEC_RK_OUT_EN
  output logic [127:0] rk_last,
`endif
  input  logic         pt_rdy
);

  // Block byte 0 is the most significant byte of every 128-bit vector.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_READY  = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] c_LAST = 4'(NR);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_rk [0:NR];
  logic [127:0] r_st;
  logic [127:0] r_pt;
  logic         r_pt_vld;
  logic         r_key_ok;

  logic         w_key_hs;
  logic         w_ct_hs;
  logic [127:0] w_rk_prev;
  logic [127:0] w_rk_cur;
  logic [127:0] w_rk_new;
  logic [127:0] w_shift_sub;
  logic [127:0] w_round;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t ^ {rc, 24'h000000};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Row r of the state is rotated right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  assign w_key_hs = key_vld && key_rdy;
  assign w_ct_hs  = ct_vld && ct_rdy;

  // r_cnt doubles as the expansion index (needs rk[cnt-1]) and the round index (needs rk[cnt]).
  always_comb begin
    w_rk_prev = '0;
    w_rk_cur  = '0;
    for (int i = 0; i <= NR; i++) begin
      if (r_cnt == 4'(i + 1)) w_rk_prev = r_rk[i];
      if (r_cnt == 4'(i))     w_rk_cur  = r_rk[i];
    end
  end

  assign w_rk_new    = key_exp(w_rk_prev, rcon(r_cnt));
  assign w_shift_sub = inv_sub_bytes(inv_shift_rows(r_st)) ^ w_rk_cur;
  assign w_round     = inv_mix_cols(w_shift_sub);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    key_rdy     = 1'b0;
    ct_rdy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        key_rdy = 1'b1;
        if (key_vld) w_state_nxt = S_EXPAND;
      end
      S_EXPAND: begin
        if (r_cnt == c_LAST) w_state_nxt = S_READY;
      end
      S_READY: begin
        key_rdy = 1'b1;
        ct_rdy  = !key_vld;
        if (key_vld)     w_state_nxt = S_EXPAND;
        else if (ct_vld) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (pt_rdy) w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else begin
      if (w_key_hs) r_rk[0] <= key_in;
      if (r_state == S_EXPAND) begin
        for (int i = 1; i <= NR; i++) begin
          if (r_cnt == 4'(i)) r_rk[i] <= w_rk_new;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_st     <= '0;
      r_pt     <= '0;
      r_pt_vld <= 1'b0;
      r_key_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (w_key_hs) begin
            r_key_ok <= 1'b0;
            r_cnt    <= 4'd1;
          end else if (w_ct_hs) begin
            r_st  <= ct_in ^ r_rk[NR];
            r_cnt <= c_LAST - 4'd1;
          end
        end
        S_EXPAND: begin
          if (r_cnt == c_LAST) r_key_ok <= 1'b1;
          else                 r_cnt    <= r_cnt + 4'd1;
        end
        S_ROUND: begin
          // The last round (rk[0]) skips InvMixColumns and lands in the output register.
          if (r_cnt == 4'd0) begin
            r_pt     <= w_shift_sub;
            r_pt_vld <= 1'b1;
          end else begin
            r_st  <= w_round;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (pt_rdy) r_pt_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign key_ok = r_key_ok;
  assign pt_vld = r_pt_vld;
  assign pt_out = r_pt;

`ifdef AES_DEC_RK_OUT_EN
  assign rk_last = r_key_ok ? r_rk[NR] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_dec_iter_ctrl                                                       |
// | Scoreboard bench for aes_dec_iter_ctrl with a table-driven AES model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_dec_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_vld;
  logic [127:0] key_in;
  logic         key_rdy;
  logic         key_ok;
  logic         ct_vld;
  logic [127:0] ct_in;
  logic         ct_rdy;
  logic         pt_vld;
  logic [127:0] pt_out;
  logic         pt_rdy;
`ifdef AES_DEC_RK_OUT_EN
  logic [127:0] rk_last;
`endif

  localparam logic [127:0] c_K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] c_PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_RK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int           n_pass  = 0;
  int           n_total = 0;
  logic [127:0] sb_q [$];
  logic [127:0] cur_key = '0;
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];

  aes_dec_iter_ctrl #(.NR(10)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_vld (key_vld),
    .key_in  (key_in),
    .key_rdy (key_rdy),
    .key_ok  (key_ok),
    .ct_vld  (ct_vld),
    .ct_in   (ct_in),
    .ct_rdy  (ct_rdy),
    .pt_vld  (pt_vld),
    .pt_out  (pt_out),
`ifdef AES_DEC_RK_OUT_EN
    .rk_last (rk_last),
`endif
    .pt_rdy  (pt_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // --- reference model: byte tables and array-based AES-128 inverse cipher ---
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xt(x);
    end
    return acc;
  endfunction

  // Walk the multiplicative group with generator 3 while tracking its inverse.
  function automatic void init_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          u[4*c+r] = isbox[s[4*((c-r+4)%4)+r]] ^ w[4*rnd+c][31-8*r -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gm(u[4*c],8'd14) ^ gm(u[4*c+1],8'd11) ^ gm(u[4*c+2],8'd13) ^ gm(u[4*c+3],8'd9);
          s[4*c+1] = gm(u[4*c],8'd9)  ^ gm(u[4*c+1],8'd14) ^ gm(u[4*c+2],8'd11) ^ gm(u[4*c+3],8'd13);
          s[4*c+2] = gm(u[4*c],8'd13) ^ gm(u[4*c+1],8'd9)  ^ gm(u[4*c+2],8'd14) ^ gm(u[4*c+3],8'd11);
          s[4*c+3] = gm(u[4*c],8'd11) ^ gm(u[4*c+1],8'd13) ^ gm(u[4*c+2],8'd9)  ^ gm(u[4*c+3],8'd14);
        end
      end else begin
        s = u;
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // --- input monitor (pushes expectations) and output monitor (pops/compares) ---
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_vld && key_rdy) cur_key = key_in;
      if (ct_vld && ct_rdy)   sb_q.push_back(model_decrypt(cur_key, ct_in));
      if (pt_vld && pt_rdy) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: got %h expected none", pt_out);
        end else begin
          chk("sb_pt", pt_out, sb_q.pop_front());
        end
      end
    end
  end

  // --- stimulus helpers ---
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [127:0] k);
    int n;
    bit stall_ok;
    key_vld = 1'b1;
    key_in  = k;
    #1;
    chk("key_rdy_before_load", 128'(key_rdy), 128'(1));
    tick();
    key_vld  = 1'b0;
    key_in   = rnd128();
    n        = 0;
    stall_ok = 1'b1;
    while (!key_ok && n < 30) begin
      if (ct_rdy || key_rdy) stall_ok = 1'b0;
      tick();
      n++;
    end
    chk("key_ok_latency", 128'(n), 128'(10));
    chk("rdy_low_in_expand", 128'(stall_ok), 128'(1));
  endtask

  task automatic send_ct(input logic [127:0] ct);
    int n;
    ct_vld = 1'b1;
    ct_in  = ct;
    #1;
    n = 0;
    while (!ct_rdy && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) fail_now("ct_accept_timeout");
    tick();
    ct_vld = 1'b0;
    ct_in  = rnd128();
  endtask

  task automatic wait_pt();
    int n;
    n = 0;
    while (!pt_vld && n < 40) begin
      tick();
      n++;
    end
    chk("pt_latency", 128'(n), 128'(10));
  endtask

  task automatic ack_pt(input int dly);
    repeat (dly) tick();
    pt_rdy = 1'b1;
    tick();
    pt_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ok_v, ok_o, ok_c, ok_k;
    init_tables();
    rst_n   = 1'b1;
    key_vld = 1'b0;
    key_in  = '0;
    ct_vld  = 1'b1;
    ct_in   = c_CT1;
    pt_rdy  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_key_ok", 128'(key_ok), 128'(0));
    chk("rst_pt_vld", 128'(pt_vld), 128'(0));
    chk("rst_pt_out", pt_out, '0);
    chk("rst_key_rdy", 128'(key_rdy), 128'(1));
    chk("rst_ct_rdy", 128'(ct_rdy), 128'(0));
    rst_n = 1'b1;

    // ct held from reset stalls until the key schedule is ready
    ok_c = 1'b1;
    repeat (5) begin
      tick();
      if (ct_rdy) ok_c = 1'b0;
    end
    chk("ct_stall_idle", 128'(ok_c), 128'(1));
    load_key(c_K1);
    send_ct(c_CT1);
    wait_pt();
    chk("vec1_pt", pt_out, c_PT1);
    ack_pt(0);

    load_key(c_K2);
`ifdef AES_DEC_RK_OUT_EN
    chk("vec2_rk_last", rk_last, c_RK2);
`endif
    send_ct(c_CT2);
    wait_pt();
    chk("vec2_pt", pt_out, c_PT2);

    // output hold under back-pressure
    ok_v = 1'b1; ok_o = 1'b1; ok_c = 1'b1; ok_k = 1'b1;
    repeat (20) begin
      tick();
      if (!pt_vld) ok_v = 1'b0;
      if (pt_out != c_PT2) ok_o = 1'b0;
      if (ct_rdy) ok_c = 1'b0;
      if (key_rdy) ok_k = 1'b0;
    end
    chk("hold_pt_vld", 128'(ok_v), 128'(1));
    chk("hold_pt_out", 128'(ok_o), 128'(1));
    chk("hold_ct_rdy_low", 128'(ok_c), 128'(1));
    chk("hold_key_rdy_low", 128'(ok_k), 128'(1));
    pt_rdy = 1'b1;
    tick();
    pt_rdy = 1'b0;
    chk("ack_pt_vld_low", 128'(pt_vld), 128'(0));
    chk("ack_ct_rdy_high", 128'(ct_rdy), 128'(1));
    chk("ack_pt_out_kept", pt_out, c_PT2);

    // simultaneous key and ct: key wins, ct waits for the new schedule
    key_vld = 1'b1; key_in = c_K1;
    ct_vld  = 1'b1; ct_in  = c_CT1;
    #1;
    chk("prio_ct_rdy", 128'(ct_rdy), 128'(0));
    chk("prio_key_rdy", 128'(key_rdy), 128'(1));
    tick();
    key_vld = 1'b0;
    n = 0;
    ok_k = 1'b1;
    while (!ct_rdy && n < 30) begin
      if (key_ok) ok_k = 1'b0;
      tick();
      n++;
    end
    chk("prio_key_ok_low", 128'(ok_k), 128'(1));
    chk("prio_ct_wait", 128'(n), 128'(10));
    tick();
    ct_vld = 1'b0;
    wait_pt();
    chk("prio_pt", pt_out, c_PT1);
    ack_pt(2);

    // back-to-back blocks with the consumer always ready
    pt_rdy = 1'b1;
    send_ct(rnd128());
    ct_vld = 1'b1;
    ct_in  = rnd128();
    n = 0;
    while (!ct_rdy && n < 40) begin
      tick();
      n++;
    end
    tick();
    ct_vld = 1'b0;
    chk("throughput", 128'(n + 1), 128'(12));
    wait_pt();
    tick();
    pt_rdy = 1'b0;

    // randomized keys and blocks against the model
    for (int k = 0; k < 5; k++) begin
      load_key(rnd128());
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        send_ct(rnd128());
        wait_pt();
        ack_pt(int'($urandom_range(0, 3)));
      end
    end

    // asynchronous reset in the middle of a decryption
    load_key(rnd128());
    send_ct(rnd128());
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("arst_pt_vld", 128'(pt_vld), 128'(0));
    chk("arst_key_ok", 128'(key_ok), 128'(0));
    chk("arst_idle_key_rdy", 128'(key_rdy), 128'(1));
    chk("arst_idle_ct_rdy", 128'(ct_rdy), 128'(0));
`ifdef AES_DEC_RK_OUT_EN
    chk("arst_rk_last", rk_last, '0);
`endif
    tick();
    rst_n  = 1'b1;
    ct_vld = 1'b1;
    ct_in  = c_CT1;
    ok_c = 1'b1;
    repeat (5) begin
      tick();
      if (ct_rdy) ok_c = 1'b0;
    end
    chk("arst_ct_stall", 128'(ok_c), 128'(1));
    load_key(c_K1);
    send_ct(c_CT1);
    wait_pt();
    chk("arst_vec1_pt", pt_out, c_PT1);
    ack_pt(0);

    repeat (3) tick();
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
